// File: rtl/ram_arbiter_2port_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  // Arbitration mode encodings for the ARB_MODE parameter.
  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_t;

endpackage

// File: rtl/ram_arbiter_2port_if.sv
// One requester's view of the shared RAM: request fields in, grant and read return out.
interface ram_arbiter_2port_if;
  import ram_arb_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  // The requester side drives the access and watches the grant and read return.
  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  // The arbiter side samples the access and answers with grant and read return.
  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/ram_arbiter_2port_grant.sv
// Grant decision for the two requesters, plus the history it depends on:
// last_grant for round-robin ties and wait_cnt for B's starvation guard.
module ram_arb_grant
  import ram_arb_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR,
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_req,
  input  logic b_req,
  output logic a_gnt,
  output logic b_gnt
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

  port_id_t   last_grant;
  logic [7:0] wait_cnt;
  logic       a_win;
  logic       b_win;
  logic       contested;

  assign contested = a_req & b_req;

  // Pick the winner this cycle; ties go by mode-specific history.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    a_win = 1'b0;
    b_win = 1'b0;
    if (contested) begin
      if (ARB_MODE == ARB_RR) begin
        if (last_grant == PORT_B) a_win = 1'b1;
        else                      b_win = 1'b1;
      end else begin
        if (wait_cnt == MAX_CNT) b_win = 1'b1;
        else                     a_win = 1'b1;
      end
    end else begin
      a_win = a_req;
      b_win = b_req;
    end
  end

  // No grant may leave the arbiter while reset is asserted.
  assign a_gnt = a_win & rst_n;
  assign b_gnt = b_win & rst_n;

  // Track the last contested winner and how long B has been refused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= PORT_B;
      wait_cnt   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (contested) last_grant <= b_win ? PORT_B : PORT_A;
      if (b_req && !b_win) begin
        if (wait_cnt != MAX_CNT) wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter_2port.sv
// Two-port arbiter in front of a single-cycle-read 16x4K RAM: muxes the granted
// access onto the RAM and steers the next-cycle read data back to its issuer.
module ram_arbiter_2port
  import ram_arb_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  ram_arbiter_2port_if.slave  a,
  ram_arbiter_2port_if.slave  b,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_write,
  output logic                mem_read,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic     a_gnt;
  logic     b_gnt;
  logic     read_issued;
  logic     rvalid_pending;
  port_id_t owner;

  ram_arb_grant #(
    .ARB_MODE (ARB_MODE),
    .MAX_WAIT (MAX_WAIT)
  ) u_grant (
    .clk   (clk),
    .rst_n (rst_n),
    .a_req (a.req),
    .b_req (b.req),
    .a_gnt (a_gnt),
    .b_gnt (b_gnt)
  );

  assign a.gnt = a_gnt;
  assign b.gnt = b_gnt;

  // Drive the RAM from whichever port won; with no grant the A side sits on the bus unstrobed.
  always_comb begin
    mem_address   = a.addr;
    mem_writedata = a.wdata;
    if (b_gnt) begin
      mem_address   = b.addr;
      mem_writedata = b.wdata;
    end
  end

  assign mem_write   = (a_gnt & a.we) | (b_gnt & b.we);
  assign mem_read    = (a_gnt & ~a.we) | (b_gnt & ~b.we);
  assign read_issued = mem_read;

  // Remember who issued this cycle's read so next cycle's RAM data goes back to them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_pending <= 1'b0;
      owner          <= PORT_A;
    end else begin
      rvalid_pending <= read_issued;
      owner          <= b_gnt ? PORT_B : PORT_A;
    end
  end

  assign a.rvalid = rvalid_pending && (owner == PORT_A);
  assign b.rvalid = rvalid_pending && (owner == PORT_B);
  assign a.rdata  = a.rvalid ? mem_readdata : '0;
  assign b.rdata  = b.rvalid ? mem_readdata : '0;

endmodule

// File: tb/tb_ram_arbiter_2port.sv
// Bench for ram_arbiter_2port: one round-robin and one fixed-priority instance,
// each in front of its own behavioural RAM.
module tb_ram_arbiter_2port;
  import ram_arb_pkg::*;

  localparam int MAXW = 4;

  typedef struct packed {
    logic        a_req;
    logic        a_we;
    logic [11:0] a_addr;
    logic [15:0] a_wdata;
    logic        b_req;
    logic        b_we;
    logic [11:0] b_addr;
    logic [15:0] b_wdata;
  } stim_t;

  typedef struct packed {
    logic        a_gnt;
    logic        b_gnt;
    logic        mem_rd;
    logic        mem_wr;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        a_rv;
    logic [15:0] a_rd;
    logic        b_rv;
    logic [15:0] b_rd;
  } obs_t;

  typedef struct packed {
    stim_t       s;
    logic        a_gnt;
    logic        b_gnt;
    logic        mem_rd;
    logic        mem_wr;
    logic [11:0] mem_addr;
    logic        a_rv;
    logic [15:0] a_rd;
    logic        b_rv;
    logic [15:0] b_rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ram_arbiter_2port_if a0 ();
  ram_arbiter_2port_if b0 ();
  ram_arbiter_2port_if a1 ();
  ram_arbiter_2port_if b1 ();

  logic [11:0] mem_address   [2];
  logic        mem_write     [2];
  logic        mem_read      [2];
  logic [15:0] mem_writedata [2];
  logic [15:0] mem_readdata  [2];
  logic [15:0] ram0 [4096];
  logic [15:0] ram1 [4096];

  ram_arbiter_2port #(.ARB_MODE(ARB_RR), .MAX_WAIT(MAXW)) dut_rr (
    .clk(clk), .rst_n(rst_n), .a(a0), .b(b0),
    .mem_address(mem_address[0]), .mem_write(mem_write[0]), .mem_read(mem_read[0]),
    .mem_writedata(mem_writedata[0]), .mem_readdata(mem_readdata[0])
  );

  ram_arbiter_2port #(.ARB_MODE(ARB_FIXED), .MAX_WAIT(MAXW)) dut_fx (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1),
    .mem_address(mem_address[1]), .mem_write(mem_write[1]), .mem_read(mem_read[1]),
    .mem_writedata(mem_writedata[1]), .mem_readdata(mem_readdata[1])
  );

  // Behavioural single-cycle-read RAMs.
  always @(posedge clk) begin
    if (mem_write[0]) ram0[mem_address[0]] <= mem_writedata[0];
    if (mem_read[0])  mem_readdata[0] <= ram0[mem_address[0]];
    if (mem_write[1]) ram1[mem_address[1]] <= mem_writedata[1];
    if (mem_read[1])  mem_readdata[1] <= ram1[mem_address[1]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int k, input stim_t s);
    if (k == 0) begin
      a0.req = s.a_req; a0.we = s.a_we; a0.addr = s.a_addr; a0.wdata = s.a_wdata;
      b0.req = s.b_req; b0.we = s.b_we; b0.addr = s.b_addr; b0.wdata = s.b_wdata;
    end else begin
      a1.req = s.a_req; a1.we = s.a_we; a1.addr = s.a_addr; a1.wdata = s.a_wdata;
      b1.req = s.b_req; b1.we = s.b_we; b1.addr = s.b_addr; b1.wdata = s.b_wdata;
    end
  endtask

  task automatic sample(input int k, output obs_t o);
    if (k == 0) begin
      o = {a0.gnt, b0.gnt, mem_read[0], mem_write[0], mem_address[0], mem_writedata[0],
           a0.rvalid, a0.rdata, b0.rvalid, b0.rdata};
    end else begin
      o = {a1.gnt, b1.gnt, mem_read[1], mem_write[1], mem_address[1], mem_writedata[1],
           a1.rvalid, a1.rdata, b1.rvalid, b1.rdata};
    end
  endtask

  // Called just after a posedge; returns just after the next posedge.
  task automatic run_cycle(input int k, input stim_t s, output obs_t o);
    drive(k, s);
    @(negedge clk);
    sample(k, o);
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t st(input logic ar, input logic aw, input logic [11:0] aa,
                               input logic [15:0] ad, input logic br, input logic bw,
                               input logic [11:0] ba, input logic [15:0] bd);
    st = {ar, aw, aa, ad, br, bw, ba, bd};
  endfunction

  function automatic vec_t mkv(input stim_t s, input logic ag, input logic bg,
                               input logic rd, input logic wr, input logic [11:0] ma,
                               input logic arv, input logic [15:0] ard,
                               input logic brv, input logic [15:0] brd);
    mkv = {s, ag, bg, rd, wr, ma, arv, ard, brv, brd};
  endfunction

  task automatic do_reset();
    drive(0, '0);
    drive(1, '0);
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Higher-level reference: arbitration history as plain integers, RAM as an array,
  // read return as a one-entry "what comes back next cycle" record.
  logic [15:0] ref_mem [4096];

  task automatic random_run(input int k, input int mode, input int ncyc);
    stim_t s;
    obs_t  o;
    int    last_b = 1;
    int    refused = 0;
    logic  pend = 1'b0, pend_b = 1'b0, ea, eb, a_keep = 1'b0, b_keep = 1'b0;
    logic  [15:0] pend_data = '0;
    logic  [11:0] g_addr;
    logic  [15:0] g_wdata;
    logic  g_we;
    for (int i = 2048; i < 4096; i++) ref_mem[i] = '0;
    s = '0;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      if (!a_keep) begin
        s.a_req   = $urandom_range(0, 3) != 0;
        s.a_we    = $urandom_range(0, 2) == 0;
        s.a_addr  = 12'h800 | 12'($urandom_range(0, 15));
        s.a_wdata = 16'($urandom);
      end
      if (!b_keep) begin
        s.b_req   = $urandom_range(0, 3) != 0;
        s.b_we    = $urandom_range(0, 2) == 0;
        s.b_addr  = 12'h800 | 12'($urandom_range(0, 15));
        s.b_wdata = 16'($urandom);
      end
      if (s.a_req && s.b_req) ea = (mode == 0) ? (last_b == 1) : (refused != MAXW);
      else                    ea = s.a_req;
      eb = s.b_req && !ea;
      g_addr  = eb ? s.b_addr : s.a_addr;
      g_wdata = eb ? s.b_wdata : s.a_wdata;
      g_we    = eb ? s.b_we : s.a_we;

      run_cycle(k, s, o);

      check($sformatf("rnd%0d c%0d a_gnt", k, c), o.a_gnt, ea);
      check($sformatf("rnd%0d c%0d b_gnt", k, c), o.b_gnt, eb);
      check($sformatf("rnd%0d c%0d mem_read", k, c), o.mem_rd, (ea || eb) && !g_we);
      check($sformatf("rnd%0d c%0d mem_write", k, c), o.mem_wr, (ea || eb) && g_we);
      check($sformatf("rnd%0d c%0d mem_address", k, c), o.mem_addr, g_addr);
      if ((ea || eb) && g_we) check($sformatf("rnd%0d c%0d mem_writedata", k, c), o.mem_wdata, g_wdata);
      check($sformatf("rnd%0d c%0d a_rvalid", k, c), o.a_rv, pend && !pend_b);
      check($sformatf("rnd%0d c%0d a_rdata", k, c), o.a_rd, (pend && !pend_b) ? pend_data : 16'h0);
      check($sformatf("rnd%0d c%0d b_rvalid", k, c), o.b_rv, pend && pend_b);
      check($sformatf("rnd%0d c%0d b_rdata", k, c), o.b_rd, (pend && pend_b) ? pend_data : 16'h0);

      if (s.a_req && s.b_req) last_b = eb ? 1 : 0;
      if (s.b_req && !eb) refused = (refused < MAXW) ? refused + 1 : MAXW;
      else                refused = 0;
      pend      = (ea || eb) && !g_we;
      pend_b    = eb;
      pend_data = ref_mem[g_addr];
      if ((ea || eb) && g_we) ref_mem[g_addr] = g_wdata;
      a_keep = s.a_req && !ea;
      b_keep = s.b_req && !eb;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t  vecs[17];
    stim_t idle, both;
    obs_t  o;

    for (int i = 0; i < 4096; i++) begin
      ram0[i] = '0;
      ram1[i] = '0;
    end
    ram0[12'h000] = 16'h0001; ram0[12'h001] = 16'h0002; ram0[12'h002] = 16'h0003;
    ram0[12'h005] = 16'hBEEF; ram0[12'h010] = 16'h1111; ram0[12'h020] = 16'h2222;
    ram1[12'h010] = 16'h1111; ram1[12'h020] = 16'h2222;
    mem_readdata[0] = '0;
    mem_readdata[1] = '0;

    // Reset state: requests present but nothing may be granted or returned.
    rst_n = 1'b0;
    drive(0, st(1, 0, 12'h005, 0, 1, 0, 12'h020, 0));
    @(posedge clk);
    @(negedge clk);
    sample(0, o);
    check("reset a_gnt", o.a_gnt, 0);
    check("reset b_gnt", o.b_gnt, 0);
    check("reset mem_read", o.mem_rd, 0);
    check("reset mem_write", o.mem_wr, 0);
    check("reset a_rvalid", o.a_rv, 0);
    check("reset b_rdata", o.b_rd, 0);
    @(posedge clk);
    #1;
    do_reset();

    // Table-driven sequence on the round-robin instance.
    idle = '0;
    both = st(1, 0, 12'h010, 0, 1, 0, 12'h020, 0);
    vecs[0]  = mkv(idle, 0, 0, 0, 0, 12'h000, 0, 16'h0, 0, 16'h0);
    vecs[1]  = mkv(st(1, 0, 12'h005, 0, 0, 0, 0, 0), 1, 0, 1, 0, 12'h005, 0, 16'h0, 0, 16'h0);
    vecs[2]  = mkv(idle, 0, 0, 0, 0, 12'h000, 1, 16'hBEEF, 0, 16'h0);
    vecs[3]  = mkv(st(0, 0, 0, 0, 1, 1, 12'h0FF, 16'h1234), 0, 1, 0, 1, 12'h0FF, 0, 16'h0, 0, 16'h0);
    vecs[4]  = mkv(st(1, 0, 12'h0FF, 0, 0, 0, 0, 0), 1, 0, 1, 0, 12'h0FF, 0, 16'h0, 0, 16'h0);
    vecs[5]  = mkv(idle, 0, 0, 0, 0, 12'h000, 1, 16'h1234, 0, 16'h0);
    vecs[6]  = mkv(st(1, 0, 12'h000, 0, 0, 0, 0, 0), 1, 0, 1, 0, 12'h000, 0, 16'h0, 0, 16'h0);
    vecs[7]  = mkv(st(1, 0, 12'h001, 0, 0, 0, 0, 0), 1, 0, 1, 0, 12'h001, 1, 16'h0001, 0, 16'h0);
    vecs[8]  = mkv(st(1, 0, 12'h002, 0, 0, 0, 0, 0), 1, 0, 1, 0, 12'h002, 1, 16'h0002, 0, 16'h0);
    vecs[9]  = mkv(idle, 0, 0, 0, 0, 12'h000, 1, 16'h0003, 0, 16'h0);
    vecs[10] = mkv(both, 1, 0, 1, 0, 12'h010, 0, 16'h0, 0, 16'h0);
    vecs[11] = mkv(both, 0, 1, 1, 0, 12'h020, 1, 16'h1111, 0, 16'h0);
    vecs[12] = mkv(both, 1, 0, 1, 0, 12'h010, 0, 16'h0, 1, 16'h2222);
    vecs[13] = mkv(both, 0, 1, 1, 0, 12'h020, 1, 16'h1111, 0, 16'h0);
    vecs[14] = mkv(both, 1, 0, 1, 0, 12'h010, 0, 16'h0, 1, 16'h2222);
    vecs[15] = mkv(both, 0, 1, 1, 0, 12'h020, 1, 16'h1111, 0, 16'h0);
    vecs[16] = mkv(idle, 0, 0, 0, 0, 12'h000, 0, 16'h0, 1, 16'h2222);

    for (int i = 0; i < 17; i++) begin
      run_cycle(0, vecs[i].s, o);
      check($sformatf("vec%0d a_gnt", i), o.a_gnt, vecs[i].a_gnt);
      check($sformatf("vec%0d b_gnt", i), o.b_gnt, vecs[i].b_gnt);
      check($sformatf("vec%0d mem_read", i), o.mem_rd, vecs[i].mem_rd);
      check($sformatf("vec%0d mem_write", i), o.mem_wr, vecs[i].mem_wr);
      check($sformatf("vec%0d mem_address", i), o.mem_addr, vecs[i].mem_addr);
      check($sformatf("vec%0d a_rvalid", i), o.a_rv, vecs[i].a_rv);
      check($sformatf("vec%0d a_rdata", i), o.a_rd, vecs[i].a_rd);
      check($sformatf("vec%0d b_rvalid", i), o.b_rv, vecs[i].b_rv);
      check($sformatf("vec%0d b_rdata", i), o.b_rd, vecs[i].b_rd);
    end

    // Reset falls mid-cycle after a granted read: no rvalid may follow.
    drive(0, st(1, 0, 12'h005, 0, 0, 0, 0, 0));
    @(negedge clk);
    sample(0, o);
    check("midrst a_gnt before", o.a_gnt, 1);
    rst_n = 1'b0;
    #1;
    sample(0, o);
    check("midrst a_gnt in reset", o.a_gnt, 0);
    check("midrst mem_read in reset", o.mem_rd, 0);
    @(posedge clk);
    #1;
    sample(0, o);
    check("midrst a_rvalid", o.a_rv, 0);
    check("midrst a_rdata", o.a_rd, 0);
    drive(0, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_cycle(0, '0, o);
    check("postrst a_gnt", o.a_gnt, 0);
    check("postrst b_gnt", o.b_gnt, 0);
    check("postrst mem_read", o.mem_rd, 0);
    check("postrst mem_write", o.mem_wr, 0);
    check("postrst a_rvalid", o.a_rv, 0);
    check("postrst b_rvalid", o.b_rv, 0);

    // Fixed priority with starvation guard: A,A,A,A,B repeating under continuous contention.
    do_reset();
    for (int c = 0; c < 15; c++) begin
      logic exp_b;
      exp_b = (c % 5) == 4;
      run_cycle(1, both, o);
      check($sformatf("fixed c%0d a_gnt", c), o.a_gnt, !exp_b);
      check($sformatf("fixed c%0d b_gnt", c), o.b_gnt, exp_b);
      if (c > 0) begin
        logic prev_b;
        prev_b = ((c - 1) % 5) == 4;
        check($sformatf("fixed c%0d a_rdata", c), o.a_rd, prev_b ? 16'h0 : 16'h1111);
        check($sformatf("fixed c%0d b_rdata", c), o.b_rd, prev_b ? 16'h2222 : 16'h0);
      end
    end

    // Randomized traffic against the reference model, both modes.
    random_run(0, ARB_RR, 400);
    random_run(1, ARB_FIXED, 400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
